// File: rtl/alu_control_mc.sv
// Execute-stage ALU control: decodes aluop/funct into a registered select code
// and sequences multi-cycle MULT/DIV with a ready/busy handshake.
module alu_control_mc #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic             flush,
  output logic [SEL_W-1:0] select,
  output logic             valid_out,
  output logic             busy,
  output logic             hilo_we,
  output logic             illegal
);

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] SEL_AND  = 4'h0;
  localparam logic [CODE_W-1:0] SEL_OR   = 4'h1;
  localparam logic [CODE_W-1:0] SEL_ADD  = 4'h2;
  localparam logic [CODE_W-1:0] SEL_XOR  = 4'h3;
  localparam logic [CODE_W-1:0] SEL_SUB  = 4'h6;
  localparam logic [CODE_W-1:0] SEL_SLT  = 4'h7;
  localparam logic [CODE_W-1:0] SEL_SLL  = 4'h8;
  localparam logic [CODE_W-1:0] SEL_SRL  = 4'h9;
  localparam logic [CODE_W-1:0] SEL_MULT = 4'hA;
  localparam logic [CODE_W-1:0] SEL_DIV  = 4'hB;
  localparam logic [CODE_W-1:0] SEL_NOR  = 4'hC;
  localparam logic [CODE_W-1:0] SEL_MFHI = 4'hD;
  localparam logic [CODE_W-1:0] SEL_MFLO = 4'hE;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic               valid_q, valid_d;
  logic               hilo_q, hilo_d;
  logic               illegal_q, illegal_d;

  logic [CODE_W-1:0]  dec_code;
  logic               dec_illegal;
  logic               dec_mul;
  logic               dec_div;

  // Pure decode of the presented op.
  always_comb begin
    dec_code    = SEL_ADD;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    dec_div     = 1'b0;
    unique case (aluop)
      2'b00: dec_code = SEL_ADD;
      2'b01: dec_code = SEL_SUB;
      2'b10: begin
        unique case (funct)
          6'b100000: dec_code = SEL_ADD;
          6'b100010: dec_code = SEL_SUB;
          6'b100100: dec_code = SEL_AND;
          6'b100101: dec_code = SEL_OR;
          6'b100110: dec_code = SEL_XOR;
          6'b100111: dec_code = SEL_NOR;
          6'b101010: dec_code = SEL_SLT;
          6'b000000: dec_code = SEL_SLL;
          6'b000010: dec_code = SEL_SRL;
          6'b011000: begin
            dec_code = SEL_MULT;
            dec_mul  = 1'b1;
          end
          6'b011010: begin
            dec_code = SEL_DIV;
            dec_div  = 1'b1;
          end
          6'b010000: dec_code = SEL_MFHI;
          6'b010010: dec_code = SEL_MFLO;
          default: begin
            dec_code    = SEL_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_code    = SEL_ADD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Next-state and registered-output logic. The counter is loaded with
  // N-1 at accept and completion fires on the edge it reads zero, so the
  // block stays busy for exactly N cycles and completes N edges after accept.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    select_d  = select_q;
    valid_d   = 1'b0;
    hilo_d    = 1'b0;
    illegal_d = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            select_d = SEL_W'(dec_code);
            if (dec_mul) begin
              state_d = ST_MUL;
              cnt_d   = MUL_LOAD;
            end else if (dec_div) begin
              state_d = ST_DIV;
              cnt_d   = DIV_LOAD;
            end else begin
              valid_d   = 1'b1;
              illegal_d = dec_illegal;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            valid_d = 1'b1;
            hilo_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      select_q  <= '0;
      valid_q   <= 1'b0;
      hilo_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      select_q  <= select_d;
      valid_q   <= valid_d;
      hilo_q    <= hilo_d;
      illegal_q <= illegal_d;
    end
  end

  // Handshake status is a direct decode of the state register.
  assign busy      = (state_q != ST_IDLE);
  assign ready     = (state_q == ST_IDLE);
  assign select    = select_q;
  assign valid_out = valid_q;
  assign hilo_we   = hilo_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed self-checking bench for alu_control_mc: decode stream, MULT/DIV
// sequencing, flush, async reset, illegal ops and a fast-multiply instance.
module tb_alu_control_mc;

  logic       clk;
  logic       rst_n;
  logic       valid_in, flush;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic       ready, valid_out, busy, hilo_we, illegal;
  logic [3:0] select;

  logic       f_valid_in, f_flush;
  logic [1:0] f_aluop;
  logic [5:0] f_funct;
  logic       f_ready, f_valid_out, f_busy, f_hilo_we, f_illegal;
  logic [3:0] f_select;

  int n_checks;
  int n_fail;

  alu_control_mc #(.SEL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready(ready),
    .aluop(aluop), .funct(funct), .flush(flush), .select(select),
    .valid_out(valid_out), .busy(busy), .hilo_we(hilo_we), .illegal(illegal)
  );

  alu_control_mc #(.SEL_W(4), .MUL_CYCLES(2), .DIV_CYCLES(15), .CNT_W(4)) u_fast (
    .clk(clk), .rst_n(rst_n), .valid_in(f_valid_in), .ready(f_ready),
    .aluop(f_aluop), .funct(f_funct), .flush(f_flush), .select(f_select),
    .valid_out(f_valid_out), .busy(f_busy), .hilo_we(f_hilo_we), .illegal(f_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed status bundle: {busy, ready, valid_out, hilo_we, illegal, select}.
  wire [8:0] obs   = {busy, ready, valid_out, hilo_we, illegal, select};
  wire [8:0] f_obs = {f_busy, f_ready, f_valid_out, f_hilo_we, f_illegal, f_select};

  function automatic logic [8:0] pack(input logic b, input logic r, input logic v,
                                      input logic h, input logic i, input logic [3:0] s);
    return {b, r, v, h, i, s};
  endfunction

  localparam int NS = 13;
  localparam logic [1:0] S_ALUOP [NS] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                          2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  localparam logic [5:0] S_FUNCT [NS] = '{6'b000000, 6'b000000, 6'b100000, 6'b100010,
                                          6'b100100, 6'b100101, 6'b101010, 6'b100110,
                                          6'b100111, 6'b000000, 6'b000010, 6'b010000,
                                          6'b010010};
  localparam logic [3:0] S_SEL   [NS] = '{4'h2, 4'h6, 4'h2, 4'h6, 4'h0, 4'h1, 4'h7,
                                          4'h3, 4'hC, 4'h8, 4'h9, 4'hD, 4'hE};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
    valid_in = v;
    aluop    = op;
    funct    = fn;
  endtask

  task automatic test_reset;
    logic [8:0] e;
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 6'b000000);
    flush = 1'b0;
    f_valid_in = 1'b0; f_aluop = 2'b00; f_funct = 6'b000000; f_flush = 1'b0;
    #2 rst_n = 1'b0;
    #3;
    e = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, e);
    end
    n_checks++;
    if (f_obs !== e) begin
      n_fail++;
      $display("FAIL reset_state_fast: got %h expected %h", f_obs, e);
    end
    #2 rst_n = 1'b1;
  endtask

  // Back-to-back single-cycle ops; the first edge after reset release accepts.
  task automatic test_back_to_back;
    logic [8:0] e;
    for (int i = 0; i < NS; i++) begin
      drive(1'b1, S_ALUOP[i], S_FUNCT[i]);
      tick();
      e = pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_SEL[i]);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %h expected %h", i, obs, e);
      end
    end
    drive(1'b0, 2'b10, 6'b100000);
    tick();
    e = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hE);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL stream_idle_hold: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_mult;
    logic [8:0] e;
    drive(1'b1, 2'b10, 6'b011000);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(1'b1, 2'b10, 6'b100000);
      e = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL mult_busy[%0d]: got %h expected %h", k, obs, e);
      end
      tick();
    end
    e = pack(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mult_done: got %h expected %h", obs, e);
    end
    tick();
    e = pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mult_next_accept: got %h expected %h", obs, e);
    end
    drive(1'b0, 2'b00, 6'b000000);
    tick();
    e = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mult_after_idle: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_div_flush;
    logic [8:0] e;
    drive(1'b1, 2'b10, 6'b011010);
    tick();
    drive(1'b0, 2'b00, 6'b000000);
    for (int k = 0; k < 3; k++) begin
      e = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL div_busy[%0d]: got %h expected %h", k, obs, e);
      end
      if (k == 2) flush = 1'b1;
      tick();
    end
    flush = 1'b0;
    for (int k = 0; k < 12; k++) begin
      e = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hB);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL div_flushed[%0d]: got %h expected %h", k, obs, e);
      end
      tick();
    end
    drive(1'b1, 2'b10, 6'b100000);
    flush = 1'b1;
    tick();
    e = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hB);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL flush_drops_op: got %h expected %h", obs, e);
    end
    flush = 1'b0;
    drive(1'b0, 2'b00, 6'b000000);
  endtask

  task automatic test_async_reset;
    logic [8:0] e;
    drive(1'b1, 2'b10, 6'b011010);
    tick();
    drive(1'b0, 2'b00, 6'b000000);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    e = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL async_reset_now: got %h expected %h", obs, e);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL async_reset_after[%0d]: got %h expected %h", k, obs, e);
      end
    end
  endtask

  task automatic test_illegal;
    logic [8:0] e;
    drive(1'b1, 2'b11, 6'b011000);
    tick();
    e = pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL illegal_aluop11: got %h expected %h", obs, e);
    end
    drive(1'b1, 2'b10, 6'b111111);
    tick();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL illegal_funct: got %h expected %h", obs, e);
    end
    drive(1'b0, 2'b00, 6'b000000);
    tick();
    e = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL illegal_clears: got %h expected %h", obs, e);
    end
  endtask

  // Fast instance: completion latency must equal the configured cycle count.
  task automatic test_sweep;
    logic [8:0] e;
    int n;
    for (int t = 0; t < 2; t++) begin
      f_valid_in = 1'b1;
      f_aluop    = 2'b10;
      f_funct    = (t == 0) ? 6'b011000 : 6'b011010;
      tick();
      f_valid_in = 1'b0;
      e = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (t == 0) ? 4'hA : 4'hB);
      n_checks++;
      if (f_obs !== e) begin
        n_fail++;
        $display("FAIL sweep_accept[%0d]: got %h expected %h", t, f_obs, e);
      end
      n = 0;
      while (n < 40) begin
        tick();
        n++;
        if (f_valid_out) break;
      end
      n_checks++;
      if (n !== ((t == 0) ? 2 : 15)) begin
        n_fail++;
        $display("FAIL sweep_latency[%0d]: got %0d expected %0d", t, n, (t == 0) ? 2 : 15);
      end
      e = pack(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, (t == 0) ? 4'hA : 4'hB);
      n_checks++;
      if (f_obs !== e) begin
        n_fail++;
        $display("FAIL sweep_done[%0d]: got %h expected %h", t, f_obs, e);
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_back_to_back();
    test_mult();
    test_div_flush();
    test_async_reset();
    test_illegal();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
